// File: rtl/cache_controller_if.sv
// CPU, cache-array and main-memory signals of the cache read controller.
// master: controller side; slave: CPU / cache array / memory side.
interface cache_controller_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_busy;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_data;

    logic [ADDR_W-1:0] lookup_addr;
    logic              cache_hit;
    logic [DATA_W-1:0] cache_data;
    logic              cache_fill;
    logic [DATA_W-1:0] fill_word0;
    logic [DATA_W-1:0] fill_word1;
    logic [DATA_W-1:0] fill_word2;
    logic [DATA_W-1:0] fill_word3;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data0;
    logic [DATA_W-1:0] mem_data1;
    logic [DATA_W-1:0] mem_data2;
    logic [DATA_W-1:0] mem_data3;

    modport master (
        input  cpu_req, cpu_addr, cache_hit, cache_data,
               mem_ready, mem_data0, mem_data1, mem_data2, mem_data3,
        output cpu_busy, cpu_ready, cpu_data, lookup_addr, cache_fill,
               fill_word0, fill_word1, fill_word2, fill_word3,
               mem_req, mem_addr
    );

    modport slave (
        output cpu_req, cpu_addr, cache_hit, cache_data,
               mem_ready, mem_data0, mem_data1, mem_data2, mem_data3,
        input  cpu_busy, cpu_ready, cpu_data, lookup_addr, cache_fill,
               fill_word0, fill_word1, fill_word2, fill_word3,
               mem_req, mem_addr
    );
endinterface

// File: rtl/cache_controller.sv
// Blocking read controller: cache lookup, line refill from main memory, critical-word bypass.
// Hit/miss statistics counters exist only when CACHE_STATS_EN is defined.
module cache_controller #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.master bus,
    output logic [STAT_W-1:0]  hit_count,
    output logic [STAT_W-1:0]  miss_count
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOOKUP   = 3'd1;
    localparam logic [2:0] MEM_WAIT = 3'd2;
    localparam logic [2:0] FILL     = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    logic [2:0]             state, state_nxt;
    logic [ADDR_W-1:0]      addr_q, addr_nxt;
    logic [DATA_W-1:0]      data_q, data_nxt;
    logic [3:0][DATA_W-1:0] line_q, line_nxt;
    logic                   busy_q, ready_q, fill_q, mreq_q;

    // State, latched transaction data and strobes decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            line_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            fill_q  <= 1'b0;
            mreq_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            data_q  <= data_nxt;
            line_q  <= line_nxt;
            busy_q  <= (state_nxt != IDLE);
            ready_q <= (state_nxt == RESP);
            fill_q  <= (state_nxt == FILL);
            mreq_q  <= (state_nxt == MEM_WAIT);
        end
    end

    // Next-state and next-data selection
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        line_nxt  = line_q;
        case (state)
            IDLE: begin
                if (bus.cpu_req) begin
                    addr_nxt  = bus.cpu_addr;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.cache_hit) begin
                    data_nxt  = bus.cache_data;
                    state_nxt = RESP;
                end else begin
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    line_nxt  = {bus.mem_data3, bus.mem_data2, bus.mem_data1, bus.mem_data0};
                    state_nxt = FILL;
                end
            end
            FILL: begin
                // requested word goes straight to the CPU while the line is written
                data_nxt  = line_q[addr_q[1:0]];
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.cpu_busy    = busy_q;
    assign bus.cpu_ready   = ready_q;
    assign bus.cpu_data    = data_q;
    assign bus.lookup_addr = addr_q;
    assign bus.cache_fill  = fill_q;
    assign bus.fill_word0  = line_q[0];
    assign bus.fill_word1  = line_q[1];
    assign bus.fill_word2  = line_q[2];
    assign bus.fill_word3  = line_q[3];
    assign bus.mem_req     = mreq_q;
    assign bus.mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0] hit_q, miss_q;

    // Saturating counters, one step per transaction when the lookup resolves
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state == LOOKUP) begin
            if (bus.cache_hit && (hit_q != '1))
                hit_q <= hit_q + STAT_W'(1);
            if (!bus.cache_hit && (miss_q != '1))
                miss_q <= miss_q + STAT_W'(1);
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller against a transaction-level timing/data model.
module tb_cache_controller;
    localparam int unsigned AW = 15;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] hit_count, miss_count;

    cache_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cache_controller #(.ADDR_W(AW), .DATA_W(DW), .STAT_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: values the outputs must hold after the current edge
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_line [4];
    int            m_hits, m_misses;
    bit            e_busy, e_ready, e_fill, e_mreq;
    bit            chk_on = 1'b0;
    bit            hold   = 1'b0;

    function automatic logic [SW-1:0] exp_cnt(input int raw);
        int top;
        top = (1 << SW) - 1;
        if (!STATS) return '0;
        return SW'((raw > top) ? top : raw);
    endfunction

    task automatic clear_model();
        m_addr = '0;
        m_data = '0;
        for (int k = 0; k < 4; k++) m_line[k] = '0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Single compare process, every cycle once the bench is running
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cpu_busy",    64'(bus.cpu_busy),    64'(e_busy));
            chk("cpu_ready",   64'(bus.cpu_ready),   64'(e_ready));
            chk("cache_fill",  64'(bus.cache_fill),  64'(e_fill));
            chk("mem_req",     64'(bus.mem_req),     64'(e_mreq));
            chk("cpu_data",    64'(bus.cpu_data),    64'(m_data));
            chk("lookup_addr", 64'(bus.lookup_addr), 64'(m_addr));
            chk("mem_addr",    64'(bus.mem_addr),    64'((int'(m_addr) / 4) * 4));
            chk("fill_word0",  64'(bus.fill_word0),  64'(m_line[0]));
            chk("fill_word1",  64'(bus.fill_word1),  64'(m_line[1]));
            chk("fill_word2",  64'(bus.fill_word2),  64'(m_line[2]));
            chk("fill_word3",  64'(bus.fill_word3),  64'(m_line[3]));
            chk("hit_count",   64'(hit_count),       64'(exp_cnt(m_hits)));
            chk("miss_count",  64'(miss_count),      64'(exp_cnt(m_misses)));
        end
    end

    // Event log used by the literal checks
    int            ready_edge [$];
    int            n_fill = 0;
    int            n_mreq = 0;
    logic [AW-1:0] last_maddr = '0;
    always @(negedge clk) begin
        if (chk_on) begin
            if (bus.cpu_ready)  ready_edge.push_back(cyc + 1);
            if (bus.cache_fill) n_fill++;
            if (bus.mem_req) begin
                n_mreq++;
                last_maddr = bus.mem_addr;
            end
        end
    end

    task automatic tick(input bit busy, input bit ready, input bit fill, input bit mreq);
        @(posedge clk);
        #1;
        e_busy  = busy;
        e_ready = ready;
        e_fill  = fill;
        e_mreq  = mreq;
    endtask

    // Inputs the controller must ignore in the coming cycle
    task automatic noise();
        bus.cpu_req    = hold ? 1'b1 : 1'($urandom);
        bus.cpu_addr   = AW'($urandom);
        bus.cache_hit  = 1'($urandom);
        bus.cache_data = $urandom;
        bus.mem_ready  = 1'($urandom);
        bus.mem_data0  = $urandom;
        bus.mem_data1  = $urandom;
        bus.mem_data2  = $urandom;
        bus.mem_data3  = $urandom;
    endtask

    task automatic reset_dut();
        noise();
        bus.cpu_req   = 1'b1;
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        tick(0, 0, 0, 0);
        clear_model();
        rst = 1'b0;
    endtask

    task automatic idle_cyc(input bit spurious_ready);
        noise();
        bus.cpu_req = 1'b0;
        if (spurious_ready) bus.mem_ready = 1'b1;
        tick(0, 0, 0, 0);
    endtask

    // One read, started with the controller idle; ends back in IDLE
    task automatic do_txn(input logic [AW-1:0] a, input bit hit, input logic [DW-1:0] hd,
                          input logic [3:0][DW-1:0] lw, input int w, input int rst_wait);
        noise();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        tick(1, 0, 0, 0);
        m_addr = a;

        noise();
        bus.cache_hit  = hit;
        bus.cache_data = hd;
        if (hit) begin
            tick(1, 1, 0, 0);
            m_data = hd;
            m_hits++;
        end else begin
            tick(1, 0, 0, 1);
            m_misses++;
            for (int i = 0; i < w; i++) begin
                noise();
                bus.mem_ready = 1'b0;
                if (i == rst_wait) begin
                    bus.mem_ready = 1'b1;
                    bus.cpu_req   = 1'b1;
                    rst = 1'b1;
                    tick(0, 0, 0, 0);
                    clear_model();
                    rst = 1'b0;
                    return;
                end
                tick(1, 0, 0, 1);
            end
            noise();
            bus.mem_ready = 1'b1;
            bus.mem_data0 = lw[0];
            bus.mem_data1 = lw[1];
            bus.mem_data2 = lw[2];
            bus.mem_data3 = lw[3];
            tick(1, 0, 1, 0);
            for (int k = 0; k < 4; k++) m_line[k] = lw[k];
            noise();
            tick(1, 1, 0, 0);
            m_data = m_line[int'(a) % 4];
        end
        noise();
        tick(0, 0, 0, 0);
    endtask

    logic [3:0][DW-1:0] rl;
    int                 f0, m0, r0, wv, rw;

    initial begin
        bus.cpu_req = 1'b0;
        noise();
        e_busy = 0; e_ready = 0; e_fill = 0; e_mreq = 0;
        clear_model();
        reset_dut();
        chk_on = 1'b1;
        chk("reset_cpu_data", 64'(bus.cpu_data), 64'h0);
        chk("reset_busy",     64'(bus.cpu_busy), 64'h0);

        // Miss with line refill and critical-word bypass
        idle_cyc(1'b0);
        f0 = n_fill;
        rl = {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0};
        do_txn(15'h1005, 1'b0, 32'h0, rl, 4, -1);
        chk("miss_mem_addr",   64'(last_maddr),    64'h1004);
        chk("miss_cpu_data",   64'(bus.cpu_data),  64'hA1);
        chk("miss_fill_once",  64'(n_fill - f0),   64'd1);
        chk("miss_fill_word3", 64'(bus.fill_word3), 64'hA3);
        chk("miss_count_1",    64'(miss_count),    STATS ? 64'd1 : 64'd0);

        // Hit: ready two edges after the sampling edge, no memory traffic
        idle_cyc(1'b0);
        m0 = n_mreq;
        r0 = cyc + 1;
        do_txn(15'h1006, 1'b1, 32'hDEADBEEF, '0, 0, -1);
        chk("hit_latency",  64'(ready_edge[ready_edge.size() - 1] - r0), 64'd2);
        chk("hit_cpu_data", 64'(bus.cpu_data), 64'hDEADBEEF);
        chk("hit_no_mreq",  64'(n_mreq - m0),  64'd0);
        chk("hit_count_1",  64'(hit_count),    STATS ? 64'd1 : 64'd0);

        // Back-to-back hits with cpu_req held high
        hold = 1'b1;
        r0 = ready_edge.size();
        for (int t = 0; t < 3; t++) do_txn(AW'($urandom), 1'b1, $urandom, '0, 0, -1);
        hold = 1'b0;
        chk("b2b_pulses", 64'(ready_edge.size() - r0), 64'd3);
        chk("b2b_gap1",   64'(ready_edge[r0 + 1] - ready_edge[r0]), 64'd3);
        chk("b2b_gap2",   64'(ready_edge[r0 + 2] - ready_edge[r0 + 1]), 64'd3);

        // Reset during the second MEM_WAIT cycle
        idle_cyc(1'b0);
        f0 = n_fill;
        r0 = ready_edge.size();
        do_txn(AW'($urandom), 1'b0, 32'h0, rl, 5, 1);
        chk("rst_mid_mreq", 64'(bus.mem_req), 64'h0);
        for (int t = 0; t < 3; t++) idle_cyc(1'b1);
        chk("rst_mid_no_fill",  64'(n_fill - f0), 64'd0);
        chk("rst_mid_no_ready", 64'(ready_edge.size() - r0), 64'd0);
        chk("rst_mid_hits",     64'(hit_count),  64'd0);
        chk("rst_mid_misses",   64'(miss_count), 64'd0);

        // Saturation of the 4-bit hit counter
        for (int t = 0; t < 17; t++) do_txn(AW'($urandom), 1'b1, $urandom, '0, 0, -1);
        chk("hit_saturate", 64'(hit_count), STATS ? 64'd15 : 64'd0);

        // Randomized traffic with idle gaps, spurious mem_ready and occasional resets
        for (int t = 0; t < 300; t++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cyc(1'($urandom));
            for (int k = 0; k < 4; k++) rl[k] = $urandom;
            wv = int'($urandom_range(0, 6));
            rw = ($urandom_range(0, 19) == 0 && wv > 0) ? int'($urandom_range(0, wv - 1)) : -1;
            do_txn(AW'($urandom), 1'($urandom), $urandom, rl, wv, rw);
        end

        idle_cyc(1'b0);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
